// File: rtl/clkspec_arbreq_src.sv
//==============================================================================
// clkspec_arbreq_src : per-client requester for the shared adder stage.
// Queues operand pairs, runs req -> data -> result handshakes, counts results.
// Revision: 1.0
//==============================================================================
`default_nettype none

module clkspec_arbreq_src #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             req,
    input  logic             gnt,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             dvalid,
    input  logic             drd,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res,
    output logic             done,
    output logic [WIDTH-1:0] res_q,
    output logic [7:0]       txn_cnt,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_DATA     = 2'd2,
        S_WAIT_RES = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               req_q, req_d;
    logic               dvalid_q, dvalid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_d;
    logic [7:0]         txn_cnt_q, txn_cnt_d;

    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    assign op_ready = (count_q != FULL_CNT);
    assign push     = op_valid && op_ready;
    assign pop      = (state_q == S_DATA) && drd;
    assign head     = mem_q[rd_ptr_q];

    assign req      = req_q;
    assign dvalid   = dvalid_q;
    assign a        = a_q;
    assign b        = b_q;
    assign done     = done_q;
    assign txn_cnt  = txn_cnt_q;
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        err_d     = err_q;
        res_d     = res_q;
        txn_cnt_d = txn_cnt_q;
        done_d    = 1'b0;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                if (gnt) state_d = S_DATA;
            end
            S_DATA: begin
                if (drd) begin
                    state_d = S_WAIT_RES;
                    wd_d    = '0;
                end
            end
            S_WAIT_RES: begin
                // A result arriving on the last allowed cycle still wins.
                if (res_valid) begin
                    res_d     = res;
                    done_d    = 1'b1;
                    txn_cnt_d = txn_cnt_q + 8'd1;
                    wd_d      = '0;
                    state_d   = (count_q != '0) ? S_REQ : S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    wd_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered off the next state so they align with it.
        req_d    = (state_d == S_REQ);
        dvalid_d = (state_d == S_DATA);
        a_d      = dvalid_d ? head[2*WIDTH-1:WIDTH] : '0;
        b_d      = dvalid_d ? head[WIDTH-1:0]       : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            req_q     <= 1'b0;
            dvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            txn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            req_q     <= req_d;
            dvalid_q  <= dvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {op_a, op_b};
    end

endmodule

`default_nettype wire

// File: tb/tb_clkspec_arbreq_src.sv
//==============================================================================
// tb_clkspec_arbreq_src : scoreboard bench with a modelled shared adder stage.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_clkspec_arbreq_src;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             req;
    logic             gnt = 1'b0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             dvalid;
    logic             drd = 1'b0;
    logic             res_valid = 1'b0;
    logic [WIDTH-1:0] res = '0;
    logic             done;
    logic [WIDTH-1:0] res_q;
    logic [7:0]       txn_cnt;
    logic             err;

    int errors = 0;
    int checks = 0;
    int exp_txn = 0;

    logic [2*WIDTH-1:0] exp_ab[$];
    logic [2*WIDTH-1:0] obs_ab[$];
    logic [WIDTH-1:0]   exp_res[$];
    logic [WIDTH-1:0]   obs_res[$];
    logic               obs_req[$];

    bit               gnt_en = 1'b0;
    bit               res_en = 1'b1;
    bit               pend   = 1'b0;
    logic [WIDTH-1:0] pend_sum = '0;

    clkspec_arbreq_src #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .req(req), .gnt(gnt), .a(a), .b(b), .dvalid(dvalid), .drd(drd),
        .res_valid(res_valid), .res(res),
        .done(done), .res_q(res_q), .txn_cnt(txn_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Shared adder stage model plus output monitor, acting on falling edges.
    initial begin
        forever begin
            @(negedge clk);
            gnt       = gnt_en && req;
            res_valid = 1'b0;
            if (pend && res_en) begin
                res_valid = 1'b1;
                res       = pend_sum;
                pend      = 1'b0;
            end
            drd = dvalid;
            if (dvalid) begin
                obs_ab.push_back({a, b});
                pend     = 1'b1;
                pend_sum = a + b;
            end
            if (done) begin
                obs_res.push_back(res_q);
                obs_req.push_back(req);
            end
        end
    end

    task automatic push_op(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb);
        logic [WIDTH-1:0] s;
        @(negedge clk); #1;
        op_valid = 1'b1;
        op_a     = pa;
        op_b     = pb;
        s        = pa + pb;
        exp_ab.push_back({pa, pb});
        exp_res.push_back(s);
        @(negedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (obs_res.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req, dvalid, a, b, done, res_q, txn_cnt, err, op_ready} !== {24'h0, 1'b1})
            begin
            errors++;
            $display("FAIL reset_state: got %h required %h",
                     {req, dvalid, a, b, done, res_q, txn_cnt, err, op_ready}, {24'h0, 1'b1});
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int req_cyc = 0;
        int dv_cyc = 0;
        bit ok;
        logic [2*WIDTH-1:0] eab, oab;
        logic [WIDTH-1:0]   er, orr;
        gnt_en = 1'b1;
        res_en = 1'b1;
        push_op(4'd3, 4'd4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (req) req_cyc++;
            if (dvalid) dv_cyc++;
        end
        wait_results(1, ok);
        checks++;
        if (!ok || req_cyc != 1 || dv_cyc != 1) begin
            errors++;
            $display("FAIL single_pulses: ok=%0d req_cycles=%0d dvalid_cycles=%0d required 1/1/1",
                     ok, req_cyc, dv_cyc);
        end
        if (ok) begin
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            er  = exp_res.pop_front(); orr = obs_res.pop_front();
            void'(obs_req.pop_front());
            exp_txn++;
            checks++;
            if (oab !== eab) begin
                errors++;
                $display("FAIL single_ab: got %h required %h", oab, eab);
            end
            checks++;
            if (orr !== er || res_q !== 4'd7) begin
                errors++;
                $display("FAIL single_res: got %0d/%0d required %0d", orr, res_q, er);
            end
        end
        checks++;
        if (txn_cnt !== 8'(exp_txn) || req !== 1'b0 || dvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: txn=%0d req=%b dvalid=%b required txn=%0d idle",
                     txn_cnt, req, dvalid, exp_txn);
        end
    endtask

    task automatic test_fill;
        int mcount = 0;
        bit ok;
        logic [WIDTH-1:0] s;
        logic [2*WIDTH-1:0] eab, oab;
        logic [WIDTH-1:0]   er, orr;
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (op_ready !== (mcount < DEPTH)) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b required %b", i, op_ready, mcount < DEPTH);
            end
            op_valid = 1'b1;
            op_a     = 4'(i + 1);
            op_b     = 4'(2 * i + 3);
            if (mcount < DEPTH) begin
                s = op_a + op_b;
                exp_ab.push_back({op_a, op_b});
                exp_res.push_back(s);
                mcount++;
            end
        end
        @(negedge clk); #1;
        op_valid = 1'b0;
        gnt_en   = 1'b1;
        wait_results(DEPTH, ok);
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (!ok || obs_res.size() != DEPTH) begin
            errors++;
            $display("FAIL fill_count: got %0d results required %0d", obs_res.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (obs_res.size() == 0 || exp_res.size() == 0) break;
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            er  = exp_res.pop_front(); orr = obs_res.pop_front();
            void'(obs_req.pop_front());
            exp_txn++;
            checks++;
            if (oab !== eab || orr !== er) begin
                errors++;
                $display("FAIL fill_order[%0d]: got ab=%h res=%h required ab=%h res=%h",
                         i, oab, orr, eab, er);
            end
        end
        exp_ab.delete(); exp_res.delete(); obs_ab.delete(); obs_res.delete(); obs_req.delete();
        checks++;
        if (txn_cnt !== 8'(exp_txn)) begin
            errors++;
            $display("FAIL fill_txn: got %0d required %0d", txn_cnt, exp_txn);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [2*WIDTH-1:0] eab, oab;
        logic [WIDTH-1:0]   er, orr;
        logic               orq;
        gnt_en = 1'b0;
        push_op(4'd9, 4'd8);
        push_op(4'd2, 4'd5);
        push_op(4'd15, 4'd15);
        gnt_en = 1'b1;
        wait_results(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results required 3", obs_res.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (obs_res.size() == 0) break;
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            er  = exp_res.pop_front(); orr = obs_res.pop_front();
            orq = obs_req.pop_front();
            exp_txn++;
            checks++;
            if (oab !== eab || orr !== er || orq !== (exp_res.size() != 0)) begin
                errors++;
                $display("FAIL b2b[%0d]: got ab=%h res=%h req=%b required ab=%h res=%h req=%b",
                         i, oab, orr, orq, eab, er, exp_res.size() != 0);
            end
        end
        checks++;
        if (txn_cnt !== 8'(exp_txn) || res_q !== 4'd14) begin
            errors++;
            $display("FAIL b2b_final: txn=%0d res_q=%0d required txn=%0d res_q=14",
                     txn_cnt, res_q, exp_txn);
        end
    endtask

    task automatic test_delayed_grant;
        bit ok = 1'b0;
        logic [2*WIDTH-1:0] eab, oab;
        logic [WIDTH-1:0]   er, orr;
        gnt_en = 1'b0;
        push_op(4'd6, 4'd7);
        for (int i = 0; i < 10; i++) begin
            if (req) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dgnt_req_rise: req=%b required 1", req);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (req !== 1'b1 || dvalid !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL dgnt_hold[%0d]: req=%b dvalid=%b err=%b required 1/0/0",
                         i, req, dvalid, err);
            end
            @(negedge clk); #1;
        end
        gnt_en = 1'b1;
        wait_results(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dgnt_result: got none required 1 result");
        end else begin
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            er  = exp_res.pop_front(); orr = obs_res.pop_front();
            void'(obs_req.pop_front());
            exp_txn++;
            if (oab !== eab || orr !== er || err !== 1'b0) begin
                errors++;
                $display("FAIL dgnt_data: got ab=%h res=%h err=%b required ab=%h res=%h err=0",
                         oab, orr, err, eab, er);
            end
        end
    endtask

    task automatic test_timeout;
        bit ok = 1'b0;
        logic [2*WIDTH-1:0] eab, oab;
        logic [WIDTH-1:0]   er, orr;
        gnt_en = 1'b1;
        res_en = 1'b0;
        push_op(4'd10, 4'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (dvalid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_dvalid: dvalid never seen required 1");
        end
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clk); #1;
            if (k == TIMEOUT) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_early: err=%b after %0d wait cycles required 0", err, k - 1);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || req !== 1'b0 || txn_cnt !== 8'(exp_txn) || obs_res.size() != 0) begin
            errors++;
            $display("FAIL tmo_flag: err=%b req=%b txn=%0d results=%0d required 1/0/%0d/0",
                     err, req, txn_cnt, obs_res.size(), exp_txn);
        end
        pend   = 1'b0;
        res_en = 1'b1;
        if (obs_ab.size() != 0) begin
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            void'(exp_res.pop_front());
            checks++;
            if (oab !== eab) begin
                errors++;
                $display("FAIL tmo_ab: got %h required %h", oab, eab);
            end
        end
        push_op(4'd1, 4'd2);
        wait_results(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_next: no result required 1");
        end else begin
            eab = exp_ab.pop_front(); oab = obs_ab.pop_front();
            er  = exp_res.pop_front(); orr = obs_res.pop_front();
            void'(obs_req.pop_front());
            exp_txn++;
            if (oab !== eab || orr !== er || err !== 1'b1 || txn_cnt !== 8'(exp_txn)) begin
                errors++;
                $display("FAIL tmo_next: ab=%h res=%h err=%b txn=%0d required ab=%h res=%h err=1 txn=%0d",
                         oab, orr, err, txn_cnt, eab, er, exp_txn);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        gnt_en = 1'b0;
        push_op(4'd4, 4'd4);
        push_op(4'd5, 4'd5);
        push_op(4'd6, 4'd6);
        gnt_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (dvalid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_dvalid: dvalid never seen required 1");
        end
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({req, dvalid, a, b, done, res_q, txn_cnt, err, op_ready} !== {24'h0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_state: got %h required %h",
                     {req, dvalid, a, b, done, res_q, txn_cnt, err, op_ready}, {24'h0, 1'b1});
        end
        exp_ab.delete(); exp_res.delete(); obs_ab.delete(); obs_res.delete(); obs_req.delete();
        exp_txn = 0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (req !== 1'b0 || obs_res.size() != 0 || res_q !== 4'd0 || txn_cnt !== 8'd0
            || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: req=%b results=%0d res_q=%0d txn=%0d ready=%b required 0/0/0/0/1",
                     req, obs_res.size(), res_q, txn_cnt, op_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_delayed_grant();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
